// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared type definitions for the dispatch stage.
//   core_structs_pkg : reservation_entry_t, the renamed-instruction payload
//                      carried from rename into the reservation stations.
//   dispatch_pkg     : functional-unit class type, class codes and the
//                      has_class() helper used to detect unmapped classes.

package core_structs_pkg;

  typedef struct packed {
    logic [5:0] rob_idx;
    logic [7:0] opcode;
    logic [5:0] prd;
    logic [5:0] prs1;
    logic [5:0] prs2;
  } reservation_entry_t;

endpackage

package dispatch_pkg;

  localparam int CLASS_W     = 2;
  localparam int NUM_CLASSES = 1 << CLASS_W;

  typedef logic [CLASS_W-1:0] fu_class_t;

  localparam fu_class_t FU_ALU = 2'd0;
  localparam fu_class_t FU_MUL = 2'd1;
  localparam fu_class_t FU_LSU = 2'd2;

  // class_mask has one bit per class code, set when at least one RS serves it.
  function automatic logic has_class(input logic [NUM_CLASSES-1:0] class_mask,
                                     input fu_class_t               cls);
    return class_mask[cls];
  endfunction

endpackage

// File: rtl/rs_dispatch_scheduler_rr_select.sv
// Round-robin selector: picks the first requesting RS strictly after ptr,
// searching circularly (ptr itself is considered last).
// Ports:
//   req         : one bit per RS, set when that RS is a legal target
//   ptr         : index of the most recently granted RS for this class
//   grant       : one-hot grant
//   grant_idx   : index of the granted RS
//   grant_valid : a grant was made
// NUM_RS must be a power of two so the index arithmetic wraps naturally.

module rr_select #(
  parameter int NUM_RS = 4,
  parameter int IDX_W  = $clog2(NUM_RS)
) (
  input  logic [NUM_RS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_RS-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_RS; i++) begin
      cand = ptr + IDX_W'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Dispatch stage between rename and the reservation stations.
// Holds up to two renamed instructions in an in-order two-slot buffer and
// steers each to an RS of its functional-unit class, round-robin among RSs
// sharing a class. Slot1 only leaves together with slot0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   valid_in   : rename valids (packed, bit1 implies bit0)
//   ready_out  : bit k = room to accept k+1 instructions this cycle
//   data_in    : renamed instructions, port 0 older
//   class_in   : functional-unit class per input port
//   rs_valid   : packed push valids per RS (port 1 implies port 0)
//   rs_data    : push data per RS and port
//   rs_ready   : RS room bits, bit k = room for k+1 pushes
//   flush      : drops buffered and incoming instructions

module rs_dispatch_scheduler
  import dispatch_pkg::*;
  import core_structs_pkg::*;
#(
  parameter int INPUT_PORTS = 2,
  parameter int NUM_RS      = 4,
  parameter int CLASS_WIDTH = 2,
  parameter logic [NUM_RS-1:0][CLASS_WIDTH-1:0] RS_CLASS = {FU_LSU, FU_MUL, FU_ALU, FU_ALU}
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [INPUT_PORTS-1:0]                  valid_in,
  output logic [INPUT_PORTS-1:0]                  ready_out,
  input  reservation_entry_t [INPUT_PORTS-1:0]    data_in,
  input  logic [INPUT_PORTS-1:0][CLASS_WIDTH-1:0] class_in,
  output logic [NUM_RS-1:0][1:0]                  rs_valid,
  output reservation_entry_t [NUM_RS-1:0][1:0]    rs_data,
  input  logic [NUM_RS-1:0][1:0]                  rs_ready,
  input  logic                                    flush
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int N_CLS = 1 << CLASS_WIDTH;

  logic [1:0]                       occ;
  reservation_entry_t [1:0]         slot_entry;
  logic [1:0][CLASS_WIDTH-1:0]      slot_class;
  logic [N_CLS-1:0][IDX_W-1:0]      rr_ptr;

  reservation_entry_t [1:0]         nxt_entry;
  logic [1:0][CLASS_WIDTH-1:0]      nxt_class;
  logic [1:0]                       nxt_occ;

  logic [N_CLS-1:0]                 class_mask;
  logic [NUM_RS-1:0]                req0, req1, gnt0, gnt1;
  logic [IDX_W-1:0]                 idx0, idx1;
  logic                             gv0, gv1;
  logic                             disp0, disp1_same, disp1_diff, same_cls;
  logic [1:0]                       dispatched, free, n_keep, pos;
  logic [INPUT_PORTS-1:0]           acc;

  always_comb begin
    class_mask = '0;
    for (int r = 0; r < NUM_RS; r++) class_mask[RS_CLASS[r]] = 1'b1;
  end

  always_comb begin
    req0 = '0;
    req1 = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      req0[r] = (RS_CLASS[r] == slot_class[0]) && rs_ready[r][0];
      req1[r] = (RS_CLASS[r] == slot_class[1]) && rs_ready[r][0];
    end
  end

  rr_select #(.NUM_RS(NUM_RS), .IDX_W(IDX_W)) u_sel0 (
    .req         (req0),
    .ptr         (rr_ptr[slot_class[0]]),
    .grant       (gnt0),
    .grant_idx   (idx0),
    .grant_valid (gv0)
  );

  rr_select #(.NUM_RS(NUM_RS), .IDX_W(IDX_W)) u_sel1 (
    .req         (req1),
    .ptr         (rr_ptr[slot_class[1]]),
    .grant       (gnt1),
    .grant_idx   (idx1),
    .grant_valid (gv1)
  );

  // A same-class pair shares slot0's RS (ports 0/1), so only one pointer
  // update per class can ever happen in a cycle.
  always_comb begin
    same_cls   = (slot_class[1] == slot_class[0]);
    disp0      = (occ != 2'd0) && gv0 && !flush;
    disp1_same = disp0 && (occ == 2'd2) && same_cls && rs_ready[idx0][1];
    disp1_diff = disp0 && (occ == 2'd2) && !same_cls && gv1;
    dispatched = 2'(disp0) + 2'(disp1_same | disp1_diff);
  end

  always_comb begin
    rs_valid = '0;
    rs_data  = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      if (disp0 && gnt0[r]) begin
        rs_valid[r][0] = 1'b1;
        rs_data[r][0]  = slot_entry[0];
        if (disp1_same) begin
          rs_valid[r][1] = 1'b1;
          rs_data[r][1]  = slot_entry[1];
        end
      end
      if (disp1_diff && gnt1[r]) begin
        rs_valid[r][0] = 1'b1;
        rs_data[r][0]  = slot_entry[1];
      end
    end
  end

  // occ >= dispatched always, so the 2-bit wrap in (2 - occ) cancels out.
  always_comb begin
    free      = 2'd2 - occ + dispatched;
    ready_out = '0;
    if (!rst && !flush) begin
      for (int k = 0; k < INPUT_PORTS; k++) ready_out[k] = (int'(free) > k);
    end
    acc = valid_in & ready_out;
  end

  // Survivors compact toward slot0, then accepted inputs append in port order.
  always_comb begin
    nxt_entry = slot_entry;
    nxt_class = slot_class;
    n_keep    = occ - dispatched;
    if (dispatched == 2'd1) begin
      nxt_entry[0] = slot_entry[1];
      nxt_class[0] = slot_class[1];
    end
    pos = n_keep;
    for (int k = 0; k < INPUT_PORTS; k++) begin
      if (acc[k] && pos < 2'd2) begin
        nxt_entry[pos[0]] = data_in[k];
        nxt_class[pos[0]] = class_in[k];
        pos = pos + 2'd1;
      end
    end
    nxt_occ = pos;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= '0;
      slot_entry <= '0;
      slot_class <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      if (disp0)      rr_ptr[slot_class[0]] <= idx0;
      if (disp1_diff) rr_ptr[slot_class[1]] <= idx1;
      slot_entry <= nxt_entry;
      slot_class <= nxt_class;
      occ        <= nxt_occ;
    end
  end

  // An instruction whose class no RS serves would block dispatch forever.
  property p_slot0_mapped;
    @(posedge clk) disable iff (rst)
      (occ != 2'd0) |-> has_class(class_mask, fu_class_t'(slot_class[0]));
  endproperty
  a_slot0_mapped: assert property (p_slot0_mapped);

endmodule
